drop_sequencer: RTL

- Controller that places one piece into the 6x7 score4 panel.
- Accepts a column/player request from the game-state logic and finds the lowest free row in that column.
- Sequences a frame-paced falling-piece animation for the RGB stage, then issues a single write command into the panel storage.
- Sits between the input/turn logic and the panel register array; the win checker sees the board only after the write.

---
 rtl/score4_pkg.sv | 21 ++
 rtl/column_scan.sv | 31 +++
 rtl/drop_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/score4_pkg.sv
// rtl/score4_pkg.sv - shared board geometry, cell encoding and placement FSM states
package score4_pkg;

  localparam int ROWS = 6;
  localparam int COLS = 7;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    PL_A  = 2'b01,
    PL_B  = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_FALL  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/column_scan.sv
// rtl/column_scan.sv - combinational lowest-free-row finder for one panel column
// panel cell (r,c) lives at bits [2*(r*COLS+c) +: 2]; row 0 is the top.
module column_scan #(
  parameter int ROWS = score4_pkg::ROWS,
  parameter int COLS = score4_pkg::COLS
) (
  input  logic [2*ROWS*COLS-1:0] panel,
  input  logic [2:0]             col,
  output logic [2:0]             target,
  output logic                   full
);
  import score4_pkg::*;

  logic [1:0] cells [ROWS];

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      cells[r] = 2'b00;
      for (int c = 0; c < COLS; c++) begin
        if (col == 3'(c)) cells[r] = panel[2*(r*COLS+c) +: 2];
      end
    end
    // Later (lower) rows overwrite earlier hits, leaving the bottom-most empty cell.
    target = 3'd0;
    for (int r = 0; r < ROWS; r++) begin
      if (cells[r] == EMPTY) target = 3'(r);
    end
    full = (cells[0] != EMPTY);
  end

endmodule

// File: rtl/drop_sequencer.sv
// rtl/drop_sequencer.sv - accepts a column/player request, animates the falling piece, writes the panel
module drop_sequencer #(
  parameter int ROWS        = score4_pkg::ROWS,
  parameter int COLS        = score4_pkg::COLS,
  parameter int FALL_FRAMES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic                   req_valid,
  input  logic [2:0]             req_col,
  input  logic                   req_player,
  output logic                   req_ready,
  input  logic [2*ROWS*COLS-1:0] panel,
  output logic                   anim_active,
  output logic [2:0]             anim_row,
  output logic [2:0]             anim_col,
  output logic                   anim_player,
  output logic                   wr_en,
  output logic [2:0]             wr_row,
  output logic [2:0]             wr_col,
  output logic [1:0]             wr_val,
  output logic                   done,
  output logic                   invalid
);
  import score4_pkg::*;

  localparam int                CNT_W     = (FALL_FRAMES > 1) ? $clog2(FALL_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FALL_FRAMES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]        COL_LIMIT = 4'(COLS);

  seq_state_t       state;
  logic [2:0]       col_q;
  logic [2:0]       target_q;
  logic             player_q;
  logic             bad_col_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       scan_target;
  logic             scan_full;

  column_scan #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_column_scan (
    .panel  (panel),
    .col    (col_q),
    .target (scan_target),
    .full   (scan_full)
  );

  assign req_ready = (state == ST_IDLE);
  // Out-of-range columns report one cycle after accept; full columns report during SCAN.
  assign invalid   = bad_col_q | ((state == ST_SCAN) & scan_full);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      col_q       <= 3'd0;
      target_q    <= 3'd0;
      player_q    <= 1'b0;
      bad_col_q   <= 1'b0;
      cnt         <= '0;
      anim_active <= 1'b0;
      anim_row    <= 3'd0;
      anim_col    <= 3'd0;
      anim_player <= 1'b0;
      wr_en       <= 1'b0;
      wr_row      <= 3'd0;
      wr_col      <= 3'd0;
      wr_val      <= 2'b00;
      done        <= 1'b0;
    end else begin
      bad_col_q <= 1'b0;
      wr_en     <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            col_q    <= req_col;
            player_q <= req_player;
            if ({1'b0, req_col} >= COL_LIMIT) bad_col_q <= 1'b1;
            else                              state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scan_full) begin
            state <= ST_IDLE;
          end else begin
            target_q    <= scan_target;
            anim_row    <= 3'd0;
            anim_col    <= col_q;
            anim_player <= player_q;
            anim_active <= 1'b1;
            cnt         <= '0;
            state       <= ST_FALL;
          end
        end
        ST_FALL: begin
          // Each row is held for FALL_FRAMES ticks; the last tick on the target row ends the fall.
          if (frame_tick) begin
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (anim_row == target_q) begin
                anim_active <= 1'b0;
                wr_en       <= 1'b1;
                wr_row      <= target_q;
                wr_col      <= col_q;
                wr_val      <= player_q ? PL_B : PL_A;
                state       <= ST_WRITE;
              end else begin
                anim_row <= anim_row + 3'd1;
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        ST_WRITE: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
